pit_ctrl: RTL



---
 rtl/pit_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/pit_ctrl.sv
// pit_ctrl: byte-stream command controller for one programmable interval timer.
//   Decodes host command frames into timer configuration and latches timer
//   interrupts into a sticky pending flag with overrun count and status readback.
//   Ports:
//     clk, reset (async, active-high)
//     in_valid/in_byte/in_ready       command byte stream from the host
//     out_valid/out_byte/out_ready    status byte stream to the host
//     pit_write_enable                one-cycle load strobe to the timer
//     pit_counter_high/low            16-bit reload count
//     pit_repeating, pit_divider_on   timer mode bits
//     pit_interrupting                one-cycle interrupt pulse from the timer
//     irq_pending                     sticky interrupt level to the host
//   Optional: define PIT_CTRL_TIMEOUT_EN to abort partial frames after
//   TIMEOUT_CYCLES idle cycles (sets err).
module pit_ctrl #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   input  logic [7:0] in_byte,
   output logic       in_ready,
   output logic       out_valid,
   output logic [7:0] out_byte,
   input  logic       out_ready,
   output logic       pit_write_enable,
   output logic [7:0] pit_counter_high,
   output logic [7:0] pit_counter_low,
   output logic       pit_repeating,
   output logic       pit_divider_on,
   input  logic       pit_interrupting,
   output logic       irq_pending
);
   typedef enum logic [2:0] {IDLE, GET_HI, GET_LO, GET_MODE, SEND_STATUS} state_t;
   state_t r_state, w_next;
   logic [7:0] r_shadow_hi, r_cnt_hi, r_cnt_lo, r_out_byte;
   logic [3:0] r_ovr;
   logic r_we, r_rep, r_div, r_out_valid, r_irq, r_err;
   logic w_in_fire, w_out_fire, w_idle_fire, w_ack, w_bad_op, w_inc, w_timeout;
   logic [7:0] w_status;
   assign in_ready         = r_state != SEND_STATUS;
   assign out_valid        = r_out_valid;
   assign out_byte         = r_out_byte;
   assign pit_write_enable = r_we;
   assign pit_counter_high = r_cnt_hi;
   assign pit_counter_low  = r_cnt_lo;
   assign pit_repeating    = r_rep;
   assign pit_divider_on   = r_div;
   assign irq_pending      = r_irq;
   assign w_in_fire   = in_valid & in_ready;
   assign w_out_fire  = r_out_valid & out_ready;
   assign w_idle_fire = w_in_fire & (r_state == IDLE);
   assign w_ack       = w_idle_fire & (in_byte == 8'h03);
   assign w_bad_op    = w_idle_fire & ((in_byte == 8'h00) | (in_byte > 8'h04));
   // an ACK landing with a new pulse keeps the flag set without counting an overrun
   assign w_inc       = pit_interrupting & r_irq & ~w_ack;
   assign w_status    = {r_irq, r_err, r_div, r_rep, r_ovr};
`ifdef PIT_CTRL_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] r_tmo;
   logic w_wait;
   assign w_wait    = (r_state == GET_HI) | (r_state == GET_LO) | (r_state == GET_MODE);
   assign w_timeout = w_wait & ~w_in_fire & (r_tmo == TW'(TIMEOUT_CYCLES - 1));
   always_ff @(posedge clk or posedge reset)
      if (reset) r_tmo <= '0;
      else       r_tmo <= (w_wait & ~w_in_fire & ~w_timeout) ? r_tmo + TW'(1) : '0;
`else
   // partial frames wait forever; the parameter only matters with the timeout built in
   assign w_timeout = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif
   always_ff @(posedge clk or posedge reset)
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:             if (w_in_fire) w_next = (in_byte == 8'h01) ? GET_HI :
                                                   (in_byte == 8'h02) ? GET_MODE :
                                                   (in_byte == 8'h04) ? SEND_STATUS : IDLE;
         GET_HI:           if (w_in_fire) w_next = GET_LO;
         GET_LO, GET_MODE: if (w_in_fire) w_next = IDLE;
         SEND_STATUS:      if (w_out_fire) w_next = IDLE;
         default:          w_next = IDLE;
      endcase
      if (w_timeout) w_next = IDLE;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_shadow_hi <= 8'h00;
         r_cnt_hi    <= 8'h00;
         r_cnt_lo    <= 8'h0A;
         r_we        <= 1'b0;
         r_rep       <= 1'b0;
         r_div       <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_byte  <= 8'h00;
         r_irq       <= 1'b0;
         r_err       <= 1'b0;
         r_ovr       <= 4'd0;
      end else begin
         r_we <= (r_state == GET_LO) & w_in_fire;
         if ((r_state == GET_HI) & w_in_fire) r_shadow_hi <= in_byte;
         // both count bytes change together so the timer never sees a half-loaded value
         if ((r_state == GET_LO) & w_in_fire) begin
            r_cnt_hi <= r_shadow_hi;
            r_cnt_lo <= in_byte;
         end
         if ((r_state == GET_MODE) & w_in_fire) begin
            r_rep <= in_byte[0];
            r_div <= in_byte[1];
         end
         if (w_idle_fire & (in_byte == 8'h04)) begin
            r_out_valid <= 1'b1;
            r_out_byte  <= w_status;
         end else if (w_out_fire) r_out_valid <= 1'b0;
         r_irq <= pit_interrupting | (r_irq & ~w_ack);
         r_err <= w_bad_op | w_timeout | (r_err & ~w_out_fire);
         r_ovr <= w_out_fire ? {3'b000, w_inc} : (w_inc & ~&r_ovr) ? r_ovr + 4'd1 : r_ovr;
      end
endmodule
